// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: FSM state encoding, the EX/MEM
//   load/store operation codes, byte-length constants and small decode helpers.
//   No ports; imported by mem_arbiter and mem_arb_lane.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RD_OFF = 3'b000;
    localparam logic [2:0] RD_LB  = 3'b001;
    localparam logic [2:0] RD_LH  = 3'b010;
    localparam logic [2:0] RD_LW  = 3'b011;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    localparam logic [1:0] WR_OFF = 2'b00;
    localparam logic [1:0] WR_SB  = 2'b01;
    localparam logic [1:0] WR_SH  = 2'b10;
    localparam logic [1:0] WR_SW  = 2'b11;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Codes 110/111 are not loads; they behave exactly like "off".
    function automatic logic is_read_op(input logic [2:0] op);
        return (op >= RD_LB) && (op <= RD_LHU);
    endfunction

    function automatic logic [2:0] read_len(input logic [2:0] op);
        case (op)
            RD_LB, RD_LBU: return LEN_B;
            RD_LH, RD_LHU: return LEN_H;
            default:       return LEN_W;
        endcase
    endfunction

    function automatic logic [2:0] write_len(input logic [1:0] op);
        case (op)
            WR_SB:   return LEN_B;
            WR_SH:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_lane.sv
// mem_arb_lane
//   Combinational datapath lane of the memory arbiter: inserts one received
//   byte into the 32-bit assembly word and sign/zero-extends the finished word
//   according to the latched load code.
// Ports
//   asm_in    in  32  current assembly register contents
//   byte_in   in  8   byte just returned by the RAM
//   byte_idx  in  2   little-endian byte lane the byte belongs to
//   op        in  3   latched load code (IF fetches use the LW code)
//   asm_next  out 32  assembly word with byte_in placed in its lane
//   ext_data  out 32  extended value of asm_in
module mem_arb_lane
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] asm_in,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  byte_idx,
    input  logic [2:0]  op,
    output logic [31:0] asm_next,
    output logic [31:0] ext_data
);

    always_comb begin
        asm_next = asm_in;
        case (byte_idx)
            2'd0: asm_next[7:0]   = byte_in;
            2'd1: asm_next[15:8]  = byte_in;
            2'd2: asm_next[23:16] = byte_in;
            default: asm_next[31:24] = byte_in;
        endcase
    end

    // Stores also pass through here with an "off" code; their assembly word
    // stays zero, so the pass-through default keeps mem_rdata at 0.
    always_comb begin
        case (op)
            RD_LB:   ext_data = {{24{asm_in[7]}}, asm_in[7:0]};
            RD_LH:   ext_data = {{16{asm_in[15]}}, asm_in[15:0]};
            RD_LBU:  ext_data = {24'd0, asm_in[7:0]};
            RD_LHU:  ext_data = {16'd0, asm_in[15:0]};
            default: ext_data = asm_in;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch (IF)
//   and data load/store (MEM). Each access is serialised into byte transfers,
//   read data is assembled and extended, and a one-cycle done pulse is given to
//   the owner. stall_o is raised while busy or while any request is pending.
//   Optional feature macro: MEM_ARB_FAIR_EN (alternate winner on IF/MEM ties);
//   without it MEM always wins ties.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   if_req/if_addr          IF word request, held until if_done
//   if_data/if_done         fetched word and completion pulse
//   mem_read/mem_write      load (3-bit) and store (2-bit) codes
//   mem_addr/mem_wdata      load/store byte address and store data
//   mem_rdata/mem_done      extended load data and completion pulse
//   ram_addr/ram_wr/ram_dout  RAM address, write strobe, write byte
//   ram_din                 RAM read byte, valid one cycle after its address
//   stall_o                 pipeline stall request
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic [2:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_o
);

    state_t            state;
    state_t            next_state;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [2:0]        op;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic              owner_mem;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic [31:0]       ext_data;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic              mem_req;
    logic              prefer_mem;
    logic              grant_mem;
    logic              grant_if;
    logic [ADDR_W-1:0] cur_addr;

    assign mem_rd_req = is_read_op(mem_read);
    assign mem_wr_req = (mem_write != WR_OFF);
    assign mem_req    = mem_rd_req | mem_wr_req;
    assign cur_addr   = base + ADDR_W'(cnt);

`ifdef MEM_ARB_FAIR_EN
    // Remembers who won the last grant so a tie goes to the other side.
    logic last_mem;
    assign prefer_mem = ~last_mem;
`else
    assign prefer_mem = 1'b1;
`endif

    assign grant_mem = (state == ST_IDLE) & mem_req & (~if_req | prefer_mem);
    assign grant_if  = (state == ST_IDLE) & if_req & ~grant_mem;

    // Gated by rst_n so every output reads 0 while reset is held.
    assign stall_o = rst_n & ((state != ST_IDLE) | mem_req | if_req);

    mem_arb_lane u_lane (
        .asm_in   (asm_q),
        .byte_in  (ram_din),
        .byte_idx (2'(cnt - 3'd1)),
        .op       (op),
        .asm_next (asm_next),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // READ runs N+1 cycles because byte k arrives one cycle after its address.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_mem)     next_state = mem_wr_req ? ST_WRITE : ST_READ;
                else if (grant_if) next_state = ST_READ;
            end
            ST_READ:  if (cnt == len)         next_state = ST_DONE;
            ST_WRITE: if (cnt == len - 3'd1)  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operand latch, byte counter and read assembly. Write wins over read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            len       <= '0;
            op        <= RD_OFF;
            base      <= '0;
            wdata     <= '0;
            owner_mem <= 1'b0;
            asm_q     <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_mem  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    asm_q <= '0;
                    if (grant_mem) begin
                        base      <= mem_addr;
                        wdata     <= mem_wdata;
                        owner_mem <= 1'b1;
                        op        <= mem_wr_req ? RD_OFF : mem_read;
                        len       <= mem_wr_req ? write_len(mem_write) : read_len(mem_read);
`ifdef MEM_ARB_FAIR_EN
                        last_mem  <= 1'b1;
`endif
                    end else if (grant_if) begin
                        base      <= if_addr;
                        wdata     <= '0;
                        owner_mem <= 1'b0;
                        op        <= RD_LW;
                        len       <= LEN_W;
`ifdef MEM_ARB_FAIR_EN
                        last_mem  <= 1'b0;
`endif
                    end
                end
                ST_READ: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0) asm_q <= asm_next;
                end
                ST_WRITE: cnt <= cnt + 3'd1;
                default:  cnt <= '0;
            endcase
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wr    = 1'b0;
        ram_dout  = 8'd0;
        if_data   = 32'd0;
        if_done   = 1'b0;
        mem_rdata = 32'd0;
        mem_done  = 1'b0;
        case (state)
            ST_READ: begin
                if (cnt < len) ram_addr = cur_addr;
            end
            ST_WRITE: begin
                ram_addr = cur_addr;
                ram_wr   = 1'b1;
                case (cnt[1:0])
                    2'd0:    ram_dout = wdata[7:0];
                    2'd1:    ram_dout = wdata[15:8];
                    2'd2:    ram_dout = wdata[23:16];
                    default: ram_dout = wdata[31:24];
                endcase
            end
            ST_DONE: begin
                if (owner_mem) begin
                    mem_done  = 1'b1;
                    mem_rdata = ext_data;
                end else begin
                    if_done = 1'b1;
                    if_data = ext_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a 256-byte synchronous RAM model
//   (address bits [7:0]). Expected values are hand-computed constants.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic [2:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        stall_o;

    logic [7:0]  ram [0:255];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .stall_o   (stall_o)
    );

    // Byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        ram_din <= ram[ram_addr[7:0]];
        if (ram_wr)  ram[ram_addr[7:0]] <= ram_dout;
        if (poke_en) ram[poke_addr] <= poke_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        step();
        poke_en   = 1'b0;
    endtask

    // Runs one MEM access from IDLE; lat counts cycles from grant to mem_done.
    task automatic do_mem(input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] data, output int lat);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        lat  = 99;
        data = 32'hDEAD_BEEF;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (mem_done === 1'b1) begin
                lat  = n;
                data = mem_rdata;
                break;
            end
        end
        mem_read  = 3'd0;
        mem_write = 2'd0;
        step();
    endtask

    task automatic test_reset();
        int n;
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_read  = 3'd0;
        mem_write = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        poke_en   = 1'b0;
        poke_addr = 8'd0;
        poke_data = 8'd0;
        repeat (2) step();
        vectors++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got if_done=%b mem_done=%b ram_addr=%h ram_wr=%b stall=%b, want all 0",
                     if_done, mem_done, ram_addr, ram_wr, stall_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (ram_addr !== 32'h10 + k) begin
                miscompares++;
                $display("[TB] FAIL reset_if_addr_step%0d: got %h want %h", k, ram_addr, 32'h10 + k);
            end
            step();
        end
        n = 0;
        while (if_done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        vectors++;
        if (if_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_if_done: got %b want 1", if_done);
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_if_fetch();
        int          lat;
        logic [31:0] data;
        poke(8'h00, 8'h13);
        poke(8'h01, 8'h57);
        poke(8'h02, 8'h9B);
        poke(8'h03, 8'hDF);
        if_addr = 32'h100;
        if_req  = 1'b1;
        lat  = 99;
        data = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (if_done === 1'b1) begin
                lat  = n;
                data = if_data;
                break;
            end
        end
        if_req = 1'b0;
        vectors++;
        if (lat != 6) begin
            miscompares++;
            $display("[TB] FAIL if_latency: got %0d want 6", lat);
        end
        vectors++;
        if (data !== 32'hDF9B5713) begin
            miscompares++;
            $display("[TB] FAIL if_data: got %h want DF9B5713", data);
        end
        step();
        vectors++;
        if (if_done !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL if_single_pulse: got done=%b stall=%b want 0 0", if_done, stall_o);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  rd;
        logic [31:0] addr;
        logic [31:0] want;
        int          want_lat;
        logic [31:0] data;
        int          lat;
        poke(8'h20, 8'h80);
        poke(8'h21, 8'h11);
        poke(8'h22, 8'h01);
        poke(8'h23, 8'h80);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin rd = 3'b001; addr = 32'h20; want = 32'hFFFFFF80; want_lat = 3; end
                1:       begin rd = 3'b100; addr = 32'h20; want = 32'h00000080; want_lat = 3; end
                2:       begin rd = 3'b010; addr = 32'h22; want = 32'hFFFF8001; want_lat = 4; end
                3:       begin rd = 3'b101; addr = 32'h22; want = 32'h00008001; want_lat = 4; end
                default: begin rd = 3'b011; addr = 32'h20; want = 32'h80011180; want_lat = 6; end
            endcase
            do_mem(rd, 2'b00, addr, 32'd0, data, lat);
            vectors++;
            if (data !== want || lat != want_lat) begin
                miscompares++;
                $display("[TB] FAIL load_op%b: got data=%h lat=%0d want data=%h lat=%0d",
                         rd, data, lat, want, want_lat);
            end
        end
    endtask

    task automatic test_store_half();
        logic [31:0] wa [0:3];
        logic [7:0]  wd [0:3];
        int          nw;
        int          nd;
        int          lat;
        logic [31:0] data;
        poke(8'h40, 8'h00);
        poke(8'h41, 8'h00);
        poke(8'h42, 8'h5A);
        nw  = 0;
        nd  = 0;
        lat = 99;
        mem_write = 2'b10;
        mem_addr  = 32'h40;
        mem_wdata = 32'hAABBCCDD;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (ram_wr === 1'b1) begin
                if (nw < 4) begin
                    wa[nw] = ram_addr;
                    wd[nw] = ram_dout;
                end
                nw++;
            end
            if (mem_done === 1'b1) begin
                if (nd == 0) lat = n;
                nd++;
                mem_write = 2'b00;
            end
        end
        vectors++;
        if (nw != 2) begin
            miscompares++;
            $display("[TB] FAIL sh_write_count: got %0d want 2", nw);
        end else begin
            vectors++;
            if (wa[0] !== 32'h40 || wd[0] !== 8'hDD || wa[1] !== 32'h41 || wd[1] !== 8'hCC) begin
                miscompares++;
                $display("[TB] FAIL sh_writes: got (%h,%h)(%h,%h) want (40,DD)(41,CC)",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
        vectors++;
        if (nd != 1 || lat != 3) begin
            miscompares++;
            $display("[TB] FAIL sh_done: got pulses=%0d lat=%0d want 1 3", nd, lat);
        end
        do_mem(3'b100, 2'b00, 32'h42, 32'd0, data, lat);
        vectors++;
        if (data !== 32'h0000005A) begin
            miscompares++;
            $display("[TB] FAIL sh_untouched_42: got %h want 0000005A", data);
        end
        do_mem(3'b101, 2'b00, 32'h40, 32'd0, data, lat);
        vectors++;
        if (data !== 32'h0000CCDD) begin
            miscompares++;
            $display("[TB] FAIL sh_readback: got %h want 0000CCDD", data);
        end
    endtask

    task automatic test_tie();
        logic first_mem;
        logic second_mem;
        logic want_second_mem;
        logic [31:0] d1;
        logic [31:0] d2;
        // Make IF the previous winner so the first tie is decided identically in both builds.
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (if_done === 1'b1) break;
        end
        if_req = 1'b0;
        step();
`ifdef MEM_ARB_FAIR_EN
        want_second_mem = 1'b0;
`else
        want_second_mem = 1'b1;
`endif
        if_req   = 1'b1;
        mem_read = 3'b011;
        mem_addr = 32'h20;
        first_mem  = 1'b0;
        second_mem = 1'b0;
        d1 = 32'd0;
        d2 = 32'd0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (if_done === 1'b1 || mem_done === 1'b1) begin
                first_mem = mem_done;
                d1 = first_mem ? mem_rdata : if_data;
                break;
            end
        end
        vectors++;
        if (first_mem !== 1'b1 || d1 !== 32'h80011180) begin
            miscompares++;
            $display("[TB] FAIL tie1_mem_first: got mem=%b data=%h want mem=1 data=80011180", first_mem, d1);
        end
        for (int n = 0; n < 20; n++) begin
            step();
            if (if_done === 1'b1 || mem_done === 1'b1) begin
                second_mem = mem_done;
                d2 = second_mem ? mem_rdata : if_data;
                break;
            end
        end
        vectors++;
        if (second_mem !== want_second_mem || d2 !== (want_second_mem ? 32'h80011180 : 32'hDF9B5713)) begin
            miscompares++;
            $display("[TB] FAIL tie2_winner: got mem=%b data=%h want mem=%b", second_mem, d2, want_second_mem);
        end
        if_req   = 1'b0;
        mem_read = 3'd0;
        step();
    endtask

    task automatic test_reset_abort();
        int          nd;
        int          nw;
        int          lat;
        logic [31:0] data;
        poke(8'h52, 8'hEE);
        mem_write = 2'b11;
        mem_addr  = 32'h50;
        mem_wdata = 32'h11223344;
        repeat (3) step();
        vectors++;
        if (ram_addr !== 32'h52 || ram_wr !== 1'b1 || ram_dout !== 8'h22) begin
            miscompares++;
            $display("[TB] FAIL sw_third_byte: got addr=%h wr=%b dout=%h want 52 1 22", ram_addr, ram_wr, ram_dout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got mem_done=%b ram_addr=%h ram_wr=%b stall=%b want all 0",
                     mem_done, ram_addr, ram_wr, stall_o);
        end
        mem_write = 2'b00;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nw = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (mem_done === 1'b1) nd++;
            if (ram_wr === 1'b1)   nw++;
        end
        vectors++;
        if (nd != 0 || nw != 0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got done=%0d writes=%0d stall=%b want 0 0 0", nd, nw, stall_o);
        end
        mem_read = 3'b110;
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL read_code_110: got stall=%b want 0", stall_o);
        end
        step();
        mem_read = 3'b000;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] want;
            case (i)
                0:       want = 32'h44;
                1:       want = 32'h33;
                default: want = 32'hEE;
            endcase
            do_mem(3'b100, 2'b00, 32'h50 + i, 32'd0, data, lat);
            vectors++;
            if (data !== want) begin
                miscompares++;
                $display("[TB] FAIL abort_ram_%0d: got %h want %h", i, data, want);
            end
        end
    endtask

    initial begin
        $display("[TB] mem_arbiter directed bench");
        test_reset();
        test_if_fetch();
        test_loads();
        test_store_half();
        test_reset_abort();
        test_tie();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
